// File: rtl/vector_logic_pkg.sv
// Shared types for the vector logic unit: operation codes, fold families, FSM states
// and the mapping from an operation to the family used to fold a frame.
package vector_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        FOLD_AND = 2'd0,
        FOLD_OR  = 2'd1,
        FOLD_XOR = 2'd2
    } fold_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Inverting ops fold with the same family as their non-inverting partner.
    function automatic fold_e op_to_fold(input op_e op);
        case (op)
            OP_AND, OP_NAND: return FOLD_AND;
            OP_XOR, OP_XNOR: return FOLD_XOR;
            default:         return FOLD_OR;
        endcase
    endfunction

endpackage

// File: rtl/vector_logic_core.sv
// Combinational per-beat logic operation; result width equals operand width.
module vector_logic_core
    import vector_logic_pkg::*;
#(
    parameter int WIDTH = 3
)(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_r
);

    always_comb begin
        o_r = '0;
        case (i_op)
            OP_AND:    o_r = i_a & i_b;
            OP_OR:     o_r = i_a | i_b;
            OP_XOR:    o_r = i_a ^ i_b;
            OP_NAND:   o_r = ~(i_a & i_b);
            OP_NOR:    o_r = ~(i_a | i_b);
            OP_XNOR:   o_r = ~(i_a ^ i_b);
            OP_NOT_A:  o_r = ~i_a;
            OP_PASS_A: o_r = i_a;
            default:   o_r = '0;
        endcase
    end

endmodule

// File: rtl/vector_logic_unit.sv
// Vector logic unit: per-beat bitwise ops with optional multi-beat folding into one
// result, behind a single valid/ready output register stage.
module vector_logic_unit
    import vector_logic_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_BEATS = 15,
    localparam int CNT_W    = $clog2(MAX_BEATS + 1)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_op,
    input  logic                 in_acc,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bitwise,
    output logic                 out_logical,
    output logic [2*WIDTH-1:0]   out_not,
    output logic [CNT_W-1:0]     out_beats
);

    function automatic logic [WIDTH-1:0] fold_apply(input fold_e f,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        case (f)
            FOLD_AND: return x & y;
            FOLD_XOR: return x ^ y;
            default:  return x | y;
        endcase
    endfunction

    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_fold;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_accept;
    logic               w_beat_logical;
    logic               w_final;

    state_e             r_state;
    fold_e              r_fold;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_logical;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_bitwise;
    logic               r_out_logical;
    logic [2*WIDTH-1:0] r_out_not;
    logic [CNT_W-1:0]   r_out_beats;

    vector_logic_core #(.WIDTH(WIDTH)) u_core (
        .i_a  (in_a),
        .i_b  (in_b),
        .i_op (op_e'(in_op)),
        .o_r  (w_r)
    );

    assign in_ready = !r_out_valid || out_ready;

    always_comb begin
        w_accept       = in_valid && in_ready;
        w_beat_logical = (|in_a) || (|in_b);
        // A plain beat arriving mid-frame also terminates the frame.
        w_final        = !in_acc || in_last;
        w_fold         = fold_apply(r_fold, r_acc, w_r);
        w_cnt_inc      = (r_cnt == CNT_W'(MAX_BEATS)) ? r_cnt : r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_fold        <= FOLD_OR;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_logical     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_bitwise <= '0;
            r_out_logical <= 1'b0;
            r_out_not     <= '0;
            r_out_beats   <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        if (in_acc && !in_last) begin
                            r_acc     <= w_r;
                            r_fold    <= op_to_fold(op_e'(in_op));
                            r_cnt     <= CNT_W'(1);
                            r_logical <= w_beat_logical;
                            r_state   <= ACCUM;
                        end else begin
                            r_out_valid   <= 1'b1;
                            r_out_bitwise <= w_r;
                            r_out_logical <= w_beat_logical;
                            r_out_not     <= ~{in_b, in_a};
                            r_out_beats   <= CNT_W'(1);
                        end
                    end
                    ACCUM: begin
                        if (w_final) begin
                            r_out_valid   <= 1'b1;
                            r_out_bitwise <= w_fold;
                            r_out_logical <= r_logical || w_beat_logical;
                            r_out_not     <= ~{in_b, in_a};
                            r_out_beats   <= w_cnt_inc;
                            r_acc         <= '0;
                            r_cnt         <= '0;
                            r_logical     <= 1'b0;
                            r_state       <= IDLE;
                        end else begin
                            r_acc     <= w_fold;
                            r_cnt     <= w_cnt_inc;
                            r_logical <= r_logical || w_beat_logical;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_bitwise = r_out_bitwise;
    assign out_logical = r_out_logical;
    assign out_not     = r_out_not;
    assign out_beats   = r_out_beats;

endmodule
